// File: rtl/minmax_tracker.sv
// minmax_tracker: per-frame running max/min tracker over a valid/ready stream.
// Tracks max, min, first-occurrence indices and a saturating sample count,
// then holds one result word until acknowledged.
// Optional frame sum accumulator enabled by defining MINMAX_TRACKER_SUM_EN.
//
// state  | meaning
// IDLE   | no frame open, ready for the first sample (result fields hold last frame)
// TRACK  | frame open, updating running extremes on each accepted sample
// REPORT | result presented on out_valid, input stalled until inp_ack
module minmax_tracker #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 4
) (
  input  logic                       inp_clk,
  input  logic                       inp_rst_n,
  input  logic                       inp_valid,
  input  logic [WIDTH-1:0]           inp_data,
  input  logic                       inp_last,
  output logic                       out_ready,
  input  logic                       inp_clear,
  output logic                       out_valid,
  input  logic                       inp_ack,
  output logic [WIDTH-1:0]           out_max,
  output logic [WIDTH-1:0]           out_min,
  output logic [COUNT_W-1:0]         out_max_idx,
  output logic [COUNT_W-1:0]         out_min_idx,
  output logic [COUNT_W-1:0]         out_count,
  output logic                       out_sat,
  output logic [WIDTH+COUNT_W-1:0]   out_sum
);

  typedef enum logic [1:0] {IDLE, TRACK, REPORT} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t               state_q;
  logic                 ready_q, valid_q, sat_q;
  logic [WIDTH-1:0]     max_q, min_q;
  logic [COUNT_W-1:0]   max_idx_q, min_idx_q, count_q;

  logic                 accept;
  logic                 gt_max, lt_min, cnt_full;
  logic [COUNT_W-1:0]   count_d;

  // Signed A>B from the sign and overflow of A-B, so -8 vs 7 orders correctly.
  function automatic logic signed_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] diff;
    logic             s;
    logic             v;
    diff = a - b;
    s    = diff[WIDTH-1];
    v    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    return !(s ^ v) && (a != b);
  endfunction

  // Handshake, extreme comparisons and saturating next count.
  always_comb begin
    accept   = inp_valid && ready_q;
    gt_max   = signed_gt(inp_data, max_q);
    lt_min   = signed_gt(min_q, inp_data);
    cnt_full = (count_q == CNT_MAX);
    count_d  = cnt_full ? count_q : count_q + 1'b1;
  end

  // Frame FSM with registered handshake outputs and result fields.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
    end else if (inp_clear) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            max_q     <= inp_data;
            min_q     <= inp_data;
            max_idx_q <= '0;
            min_idx_q <= '0;
            count_q   <= COUNT_W'(1);
            sat_q     <= 1'b0;
            if (inp_last) begin
              state_q <= REPORT;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state_q <= TRACK;
            end
          end
        end
        TRACK: begin
          if (accept) begin
            // Pre-increment count is the index; it pins at CNT_MAX once saturated.
            if (gt_max) begin
              max_q     <= inp_data;
              max_idx_q <= count_q;
            end
            if (lt_min) begin
              min_q     <= inp_data;
              min_idx_q <= count_q;
            end
            count_q <= count_d;
            if (cnt_full) sat_q <= 1'b1;
            if (inp_last) begin
              state_q <= REPORT;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (inp_ack) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MINMAX_TRACKER_SUM_EN
  logic [WIDTH+COUNT_W-1:0] sum_q;
  logic [WIDTH+COUNT_W-1:0] sample_sext;

  // Sign-extend the sample to the accumulator width.
  always_comb begin
    sample_sext = {{COUNT_W{inp_data[WIDTH-1]}}, inp_data};
  end

  // Wrapping frame sum: loaded by the first sample, accumulated afterwards.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      sum_q <= '0;
    end else if (inp_clear) begin
      sum_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) sum_q <= sample_sext;
      else                 sum_q <= sum_q + sample_sext;
    end
  end

  assign out_sum = sum_q;
`else
  assign out_sum = '0;
`endif

  assign out_ready   = ready_q;
  assign out_valid   = valid_q;
  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
  assign out_count   = count_q;
  assign out_sat     = sat_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker with hand-computed expected results.
module tb_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, last, clear, ack;
  logic [3:0] data;
  logic       ready, rvalid, sat;
  logic [3:0] maxv, minv, max_idx, min_idx, count;
  logic [7:0] sum;

  int vectors = 0;
  int miscompares = 0;

  minmax_tracker dut (
    .inp_clk    (clk),
    .inp_rst_n  (rst_n),
    .inp_valid  (valid),
    .inp_data   (data),
    .inp_last   (last),
    .out_ready  (ready),
    .inp_clear  (clear),
    .out_valid  (rvalid),
    .inp_ack    (ack),
    .out_max    (maxv),
    .out_min    (minv),
    .out_max_idx(max_idx),
    .out_min_idx(min_idx),
    .out_count  (count),
    .out_sat    (sat),
    .out_sum    (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_sum(input logic [7:0] v);
`ifdef MINMAX_TRACKER_SUM_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    valid = 1'b1;
    data  = d;
    last  = l;
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b1; data = 4'd3; last = 1'b0; clear = 1'b0; ack = 1'b0;

    // Reset with valid asserted: everything stays zero.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_valid", rvalid, 0);
    chk("rst_count", count, 0);
    chk("rst_max", maxv, 0);
    chk("rst_sum", sum, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", ready, 0);
    tick();
    chk("rel_ready_after_edge", ready, 1);
    chk("rel_no_accept", count, 0);

    // Frame 3,-2,7,7,-8(last); data 3 is already on the bus.
    tick();
    chk("f1_first_count", count, 1);
    chk("f1_first_max", maxv, 4'h3);
    valid = 1'b0;
    send(4'hE, 1'b0);
    send(4'h7, 1'b0);
    send(4'h7, 1'b0);
    chk("f1_not_valid_yet", rvalid, 0);
    send(4'h8, 1'b1);
    chk("f1_valid", rvalid, 1);
    chk("f1_ready", ready, 0);
    chk("f1_max", maxv, 4'h7);
    chk("f1_min", minv, 4'h8);
    chk("f1_max_idx", max_idx, 2);
    chk("f1_min_idx", min_idx, 4);
    chk("f1_count", count, 5);
    chk("f1_sat", sat, 0);
    chk("f1_sum", sum, exp_sum(8'h07));
    do_ack();
    chk("f1_ack_valid", rvalid, 0);
    chk("f1_ack_ready", ready, 1);
    chk("f1_idle_hold_max", maxv, 4'h7);

    // Single-sample frame -8, held in REPORT with a stalled sample.
    send(4'h8, 1'b1);
    chk("f2_valid", rvalid, 1);
    chk("f2_max", maxv, 4'h8);
    chk("f2_min", minv, 4'h8);
    chk("f2_max_idx", max_idx, 0);
    chk("f2_min_idx", min_idx, 0);
    chk("f2_count", count, 1);
    chk("f2_sum", sum, exp_sum(8'hF8));
    valid = 1'b1;
    data  = 4'h5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("f2_hold_ready", ready, 0);
      chk("f2_hold_valid", rvalid, 1);
      chk("f2_hold_max", maxv, 4'h8);
      chk("f2_hold_count", count, 1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    valid = 1'b0;
    chk("f2_ack_valid", rvalid, 0);
    chk("f2_ack_no_accept", count, 1);

    // 17 zeros then 1(last): count saturates at 15.
    for (int i = 0; i < 15; i++) send(4'h0, 1'b0);
    chk("f3_count15", count, 15);
    send(4'h0, 1'b0);
    send(4'h0, 1'b0);
    send(4'h1, 1'b1);
    chk("f3_valid", rvalid, 1);
    chk("f3_count", count, 15);
    chk("f3_sat", sat, 1);
    chk("f3_max", maxv, 4'h1);
    chk("f3_max_idx", max_idx, 15);
    chk("f3_min", minv, 4'h0);
    chk("f3_min_idx", min_idx, 0);
    chk("f3_sum", sum, exp_sum(8'h01));
    do_ack();

    // Clear mid-frame drops the concurrent sample.
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    valid = 1'b1; data = 4'h7; clear = 1'b1;
    tick();
    clear = 1'b0; valid = 1'b0;
    chk("clr_valid", rvalid, 0);
    chk("clr_max", maxv, 0);
    chk("clr_min", minv, 0);
    chk("clr_count", count, 0);
    chk("clr_sat", sat, 0);
    chk("clr_ready", ready, 1);
    chk("clr_sum", sum, 0);
    send(4'h2, 1'b1);
    chk("f4_valid", rvalid, 1);
    chk("f4_max", maxv, 4'h2);
    chk("f4_min", minv, 4'h2);
    chk("f4_count", count, 1);
    do_ack();

    // Async reset mid-frame.
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    chk("f5_pre_count", count, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_max", maxv, 0);
    chk("arst_ready", ready, 0);
    chk("arst_sum", sum, 0);
    rst_n = 1'b1;
    tick();
    chk("arst_rel_ready", ready, 1);
    send(4'hF, 1'b1);
    chk("f5_valid", rvalid, 1);
    chk("f5_count", count, 1);
    chk("f5_max", maxv, 4'hF);
    chk("f5_min", minv, 4'hF);
    chk("f5_sum", sum, exp_sum(8'hFF));
    do_ack();
    chk("f5_ack_valid", rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
